approx_mul_err_sweeper: RTL and testbench



---
 rtl/approx_mul_err_sweeper_if.sv | 36 +++
 rtl/approx_mul_err_sweeper.sv | 117 +++++++++++
 tb/tb_approx_mul_err_sweeper.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/approx_mul_err_sweeper_if.sv
// Host/multiplier-side bundle for approx_mul_err_sweeper.
// APPROX_SQERR_EN adds the err_sqsum result bus.
interface approx_mul_err_sweeper_if #(
    parameter int W = 6
);
    logic             start;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic [2*W-1:0]   approx_p;
    logic             busy;
    logic             done;
    logic [2*W:0]     err_count;
    logic [4*W-1:0]   err_sum;
    logic [2*W-1:0]   max_err;
`ifdef APPROX_SQERR_EN
    logic [6*W-1:0]   err_sqsum;

    modport master (
        output start, approx_p,
        input  op_a, op_b, busy, done, err_count, err_sum, max_err, err_sqsum
    );
    modport slave (
        input  start, approx_p,
        output op_a, op_b, busy, done, err_count, err_sum, max_err, err_sqsum
    );
`else
    modport master (
        output start, approx_p,
        input  op_a, op_b, busy, done, err_count, err_sum, max_err
    );
    modport slave (
        input  start, approx_p,
        output op_a, op_b, busy, done, err_count, err_sum, max_err
    );
`endif
endinterface

// File: rtl/approx_mul_err_sweeper.sv
// Exhaustive operand sweeper and error accumulator for an external approximate multiplier.
// Optional APPROX_SQERR_EN adds a sum-of-squared-error accumulator (err_sqsum).
module approx_mul_err_sweeper #(
    parameter int W   = 6,
    parameter int LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    approx_mul_err_sweeper_if.slave     bus
);
    localparam int PW = 2 * W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   idx;
    logic [2:0]      drain_cnt;
    logic [LAT:0]    pv;
    logic [PW-1:0]   pe [0:LAT];
    logic [PW-1:0]   issue_prod;
    logic [PW-1:0]   d;

    assign issue_prod = PW'(idx[PW-1:W]) * PW'(idx[W-1:0]);

    // Stage LAT of the exact-product line lines up with the returned approx_p.
    // NOTE: every path assigns d, so this stays combinational with no latch.
    always_comb begin
        d = '0;
        if (bus.approx_p >= pe[LAT])
            d = bus.approx_p - pe[LAT];
        else
            d = pe[LAT] - bus.approx_p;
    end

`ifdef APPROX_SQERR_EN
    logic [4*W-1:0] d_sq;
    assign d_sq = (4*W)'(d) * (4*W)'(d);
`endif

    // NOTE: the product line has no reset; its contents only count when pv marks them valid.
    always_ff @(posedge clk) begin
        pe[0] <= issue_prod;
        for (int j = 1; j <= LAT; j++)
            pe[j] <= pe[j-1];
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            drain_cnt     <= '0;
            pv            <= '0;
            bus.op_a      <= '0;
            bus.op_b      <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err_count <= '0;
            bus.err_sum   <= '0;
            bus.max_err   <= '0;
`ifdef APPROX_SQERR_EN
            bus.err_sqsum <= '0;
`endif
        end else begin
            pv[0] <= (state == RUN);
            for (int j = 1; j <= LAT; j++)
                pv[j] <= pv[j-1];

            if (pv[LAT]) begin
                bus.err_count <= bus.err_count + (PW+1)'(d != '0);
                bus.err_sum   <= bus.err_sum + (4*W)'(d);
                if (d > bus.max_err)
                    bus.max_err <= d;
`ifdef APPROX_SQERR_EN
                bus.err_sqsum <= bus.err_sqsum + (6*W)'(d_sq);
`endif
            end

            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state         <= RUN;
                        idx           <= '0;
                        bus.busy      <= 1'b1;
                        bus.done      <= 1'b0;
                        bus.err_count <= '0;
                        bus.err_sum   <= '0;
                        bus.max_err   <= '0;
`ifdef APPROX_SQERR_EN
                        bus.err_sqsum <= '0;
`endif
                    end
                end
                RUN: begin
                    bus.op_a <= idx[PW-1:W];
                    bus.op_b <= idx[W-1:0];
                    idx      <= idx + 1'b1;
                    if (idx == '1) begin
                        state     <= DRAIN;
                        drain_cnt <= 3'(LAT);
                    end
                end
                DRAIN: begin
                    // Wait until the last pair's compare lands in the accumulators.
                    if (drain_cnt == '0) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_approx_mul_err_sweeper.sv
// Self-checking bench: three sweepers (LAT 0/1/3) against behavioural multiplier and error models.
module tb_approx_mul_err_sweeper;
    localparam int W  = 6;
    localparam int NW = 1 << W;
    localparam int NP = 1 << (2 * W);
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    int   mode;
    logic [7:0] err_tab [NP];

    int ncmp  = 0;
    int nfail = 0;

    logic   done_w [NI];
    logic   busy_w [NI];
    longint cnt_w [NI], sum_w [NI], max_w [NI], sq_w [NI], opa_w [NI], opb_w [NI];

    always #5 clk = ~clk;

    function automatic int lat_of(input int g);
        return (g == 0) ? 0 : (g == 1) ? 1 : 3;
    endfunction

    // Behavioural approximate multiplier: 0 exact, 1 stuck-at-zero, 2 bit-0 flip, 3 random table.
    function automatic logic [2*W-1:0] approx_model(input int m, input logic [W-1:0] a,
                                                    input logic [W-1:0] b, input logic [7:0] r);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (m)
            0:       return p;
            1:       return '0;
            2:       return p ^ 12'd1;
            default: return (r[7:6] == 2'b00) ? p : (p ^ {r[5:3], 6'b0, r[2:0]});
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L = (g == 0) ? 0 : (g == 1) ? 1 : 3;
        approx_mul_err_sweeper_if #(.W(W)) bus ();
        logic [2*W-1:0] f_now;
        logic [2*W-1:0] pipe [0:7];

        assign f_now = approx_model(mode, bus.op_a, bus.op_b, err_tab[{bus.op_a, bus.op_b}]);
        always @(posedge clk) begin
            pipe[0] <= f_now;
            for (int j = 1; j < 8; j++) pipe[j] <= pipe[j-1];
        end
        assign bus.approx_p = (L == 0) ? f_now : pipe[(L == 0) ? 0 : L - 1];
        assign bus.start    = start;

        approx_mul_err_sweeper #(.W(W), .LAT(L)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign done_w[g] = bus.done;
        assign busy_w[g] = bus.busy;
        assign cnt_w[g]  = longint'(bus.err_count);
        assign sum_w[g]  = longint'(bus.err_sum);
        assign max_w[g]  = longint'(bus.max_err);
        assign opa_w[g]  = longint'(bus.op_a);
        assign opb_w[g]  = longint'(bus.op_b);
`ifdef APPROX_SQERR_EN
        assign sq_w[g]   = longint'(bus.err_sqsum);
`else
        assign sq_w[g]   = 0;
`endif
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference metrics from plain arithmetic over every operand pair.
    task automatic ref_model(input int m, output longint c, output longint s,
                             output longint mx, output longint sq);
        longint p, ap, dd;
        c = 0; s = 0; mx = 0; sq = 0;
        for (int a = 0; a < NW; a++) begin
            for (int b = 0; b < NW; b++) begin
                p  = longint'(a * b);
                ap = longint'(approx_model(m, W'(a), W'(b), err_tab[a * NW + b]));
                dd = (ap > p) ? ap - p : p - ap;
                if (dd != 0) c++;
                s += dd;
                if (dd > mx) mx = dd;
                sq += dd * dd;
            end
        end
    endtask

    task automatic check_metrics(input string tag, input int g, input longint ec, input longint es,
                                 input longint em, input longint eq);
        check($sformatf("%s[L%0d] err_count", tag, lat_of(g)), cnt_w[g], ec);
        check($sformatf("%s[L%0d] err_sum", tag, lat_of(g)), sum_w[g], es);
        check($sformatf("%s[L%0d] max_err", tag, lat_of(g)), max_w[g], em);
`ifdef APPROX_SQERR_EN
        check($sformatf("%s[L%0d] err_sqsum", tag, lat_of(g)), sq_w[g], eq);
`endif
    endtask

    task automatic sweep(input string tag, input int m, input bit extra);
        longint ec, es, em, eq;
        int dcyc [NI];
        int c;
        ref_model(m, ec, es, em, eq);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        for (int g = 0; g < NI; g++) dcyc[g] = -1;
        while (c < NP + 20 && (dcyc[0] < 0 || dcyc[1] < 0 || dcyc[2] < 0)) begin
            start = (extra && (c + 1 == 10 || c + 1 == 2000)) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            c++;
            if (c == 100) check($sformatf("%s busy_mid", tag), longint'(busy_w[1]), 1);
            for (int g = 0; g < NI; g++)
                if (done_w[g] === 1'b1 && dcyc[g] < 0) dcyc[g] = c;
        end
        start = 1'b0;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("%s[L%0d] done_cycle", tag, lat_of(g)), dcyc[g], NP + lat_of(g) + 1);
            check_metrics(tag, g, ec, es, em, eq);
        end
    endtask

    initial begin
        longint ec, es, em, eq;
        int c;
        int npulse [NI], rise1 [NI];
        logic prev_done [NI], chk_next [NI];

        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        for (int i = 0; i < NP; i++) err_tab[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("reset[L%0d] busy", lat_of(g)), longint'(busy_w[g]), 0);
            check($sformatf("reset[L%0d] done", lat_of(g)), longint'(done_w[g]), 0);
            check($sformatf("reset[L%0d] op_a", lat_of(g)), opa_w[g], 0);
            check($sformatf("reset[L%0d] op_b", lat_of(g)), opb_w[g], 0);
            check_metrics("reset", g, 0, 0, 0, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        sweep("exact", 0, 1'b0);
        sweep("stuck0", 1, 1'b0);
        sweep("flip0", 2, 1'b0);
        sweep("rand_extra_start", 3, 1'b1);

        // Reset in the middle of a sweep, then a clean sweep.
        @(negedge clk);
        mode  = 3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (1499) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("midrst[L%0d] busy", lat_of(g)), longint'(busy_w[g]), 0);
            check($sformatf("midrst[L%0d] done", lat_of(g)), longint'(done_w[g]), 0);
            check($sformatf("midrst[L%0d] op_a", lat_of(g)), opa_w[g], 0);
            check($sformatf("midrst[L%0d] op_b", lat_of(g)), opb_w[g], 0);
            check_metrics("midrst", g, 0, 0, 0, 0);
        end
        rst_n = 1'b1;
        sweep("after_rst", 3, 1'b0);

        // start held high: back-to-back sweeps, done one cycle each.
        ref_model(3, ec, es, em, eq);
        for (int g = 0; g < NI; g++) begin
            npulse[g] = 0; rise1[g] = 0; prev_done[g] = 1'b1; chk_next[g] = 1'b0;
        end
        @(negedge clk);
        mode  = 3;
        start = 1'b1;
        @(posedge clk); #1;
        for (int g = 0; g < NI; g++) prev_done[g] = done_w[g];
        c = 0;
        while (c < 2 * NP + 40 && (npulse[0] < 2 || npulse[1] < 2 || npulse[2] < 2)) begin
            @(posedge clk); #1;
            c++;
            for (int g = 0; g < NI; g++) begin
                if (chk_next[g]) begin
                    check($sformatf("held[L%0d] done_one_cycle", lat_of(g)), longint'(done_w[g]), 0);
                    check($sformatf("held[L%0d] cleared_count", lat_of(g)), cnt_w[g], 0);
                    check($sformatf("held[L%0d] cleared_sum", lat_of(g)), sum_w[g], 0);
                    chk_next[g] = 1'b0;
                end
                if (done_w[g] === 1'b1 && prev_done[g] !== 1'b1 && npulse[g] < 2) begin
                    npulse[g]++;
                    if (npulse[g] == 1) begin
                        check($sformatf("held[L%0d] first_done", lat_of(g)), c, NP + lat_of(g) + 1);
                        rise1[g] = c;
                    end else begin
                        check($sformatf("held[L%0d] done_period", lat_of(g)), c - rise1[g],
                              NP + lat_of(g) + 2);
                    end
                    check_metrics("held", g, ec, es, em, eq);
                    chk_next[g] = 1'b1;
                end
                prev_done[g] = done_w[g];
            end
        end
        start = 1'b0;
        for (int g = 0; g < NI; g++)
            check($sformatf("held[L%0d] pulses", lat_of(g)), npulse[g], 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
